// File: rtl/switch_box_param_pkg.sv
// Shared constants and source-track mapping for the parametrised switch box.
package sb_pkg;

    localparam int SIDE_0 = 0;
    localparam int SIDE_1 = 1;
    localparam int SIDE_2 = 2;
    localparam int SIDE_3 = 3;
    localparam int NUM_SIDES = 4;

    localparam logic [1:0] SEL_PE = 2'd3;

    localparam int FIELD_W         = 4;
    localparam int FIELDS_PER_WORD = 8;

    // Bit 3 of each field is reserved: never stored, always reads back 0.
    localparam logic [FIELD_W-1:0] FIELD_WR_MASK = 4'b0111;

    function automatic int sb_src_side(input int s, input int k);
        return (s + k + 1) % NUM_SIDES;
    endfunction

    function automatic int sb_src_track(input int s, input int k, input int t, input int n);
        return (t + sb_src_side(s, k) + n - 1) % n;
    endfunction

endpackage

// File: rtl/sb_track_out.sv
// One routed output: 4:1 source mux with a pipeline register that always
// tracks the mux, so enabling the register never exposes a stale value.
module sb_track_out
    import sb_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [3:0][WIDTH-1:0] cand_i,
    input  logic [1:0]            sel_i,
    input  logic                  reg_en_i,
    output logic [WIDTH-1:0]      out_o
);

    logic [WIDTH-1:0] mux_d;
    logic [WIDTH-1:0] out_q;

    assign mux_d = cand_i[sel_i];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_q <= '0;
        end else begin
            out_q <= mux_d;
        end
    end

    assign out_o = reg_en_i ? out_q : mux_d;

endmodule

// File: rtl/switch_box_param.sv
// N-track, W-bit routing switch box with per-output source select and
// pipeline enable, configured through a word-addressed register file.
module switch_box_param
    import sb_pkg::*;
#(
    parameter int         WIDTH         = 1,
    parameter int         NUM_TRACKS    = 4,
    parameter logic [3:0] OUT_SIDE_MASK = 4'b1111,
    parameter int         CFG_ADDR_W    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [4*NUM_TRACKS*WIDTH-1:0]      in_wire,
    input  logic [WIDTH-1:0]                   pe_output,
    output logic [4*NUM_TRACKS*WIDTH-1:0]      out_wire,
    input  logic                               config_en,
    input  logic                               config_we,
    input  logic [CFG_ADDR_W-1:0]              config_addr,
    input  logic [31:0]                        config_data,
    output logic [31:0]                        config_rd_data,
    output logic                               config_rd_valid
);

    localparam int NUM_OUT       = NUM_SIDES * NUM_TRACKS;
    localparam int NUM_CFG_WORDS = (NUM_OUT + FIELDS_PER_WORD - 1) / FIELDS_PER_WORD;

    logic [FIELD_W-1:0] field_q [NUM_OUT];
    logic [FIELD_W-1:0] field_d [NUM_OUT];
    logic [31:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q;
    logic               addr_ok;
    logic               cfg_wr;
    logic               cfg_rd;

    assign addr_ok = 32'(config_addr) < 32'(NUM_CFG_WORDS);
    assign cfg_wr  = config_en & config_we & addr_ok;
    assign cfg_rd  = config_en & ~config_we;

    // Masked sides are forced to zero here so their fields never hold state.
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            field_d[o] = field_q[o];
            if (cfg_wr && (config_addr == CFG_ADDR_W'(o / FIELDS_PER_WORD))) begin
                field_d[o] = config_data[(o % FIELDS_PER_WORD) * FIELD_W +: FIELD_W]
                             & FIELD_WR_MASK;
            end
            if (!OUT_SIDE_MASK[o / NUM_TRACKS]) begin
                field_d[o] = '0;
            end
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (cfg_rd) begin
            rd_data_d = '0;
            for (int o = 0; o < NUM_OUT; o++) begin
                if (addr_ok && (config_addr == CFG_ADDR_W'(o / FIELDS_PER_WORD))) begin
                    rd_data_d[(o % FIELDS_PER_WORD) * FIELD_W +: FIELD_W] = field_q[o];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                field_q[o] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                field_q[o] <= field_d[o];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= cfg_rd;
        end
    end

    assign config_rd_data  = rd_data_q;
    assign config_rd_valid = rd_valid_q;

    for (genvar s = SIDE_0; s <= SIDE_3; s++) begin : g_side
        for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
            localparam int O = s * NUM_TRACKS + t;
            if (OUT_SIDE_MASK[s]) begin : g_act
                logic [3:0][WIDTH-1:0] cand;
                for (genvar k = 0; k < 3; k++) begin : g_src
                    localparam int SRC = sb_src_side(s, k) * NUM_TRACKS
                                       + sb_src_track(s, k, t, NUM_TRACKS);
                    assign cand[k] = in_wire[SRC*WIDTH +: WIDTH];
                end
                assign cand[SEL_PE] = pe_output;

                sb_track_out #(.WIDTH(WIDTH)) u_out (
                    .clk_i    (clk),
                    .rst_n_i  (reset),
                    .cand_i   (cand),
                    .sel_i    (field_q[O][1:0]),
                    .reg_en_i (field_q[O][2]),
                    .out_o    (out_wire[O*WIDTH +: WIDTH])
                );
            end else begin : g_off
                assign out_wire[O*WIDTH +: WIDTH] = '0;
            end
        end
    end

endmodule

// File: tb/tb_switch_box_param.sv
// Directed bench: a 4-track 1-bit box with sides 2/3 masked, and a
// 6-track 8-bit box with all sides active.
module tb_switch_box_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Box A: NUM_TRACKS=4, WIDTH=1, OUT_SIDE_MASK=4'b0011
    logic [15:0] in_a, out_a;
    logic        pe_a;
    logic        en_a, we_a, rv_a;
    logic [7:0]  addr_a;
    logic [31:0] data_a, rd_a;

    // Box B: NUM_TRACKS=6, WIDTH=8, OUT_SIDE_MASK=4'b1111
    logic [191:0] in_b, out_b;
    logic [7:0]   pe_b;
    logic         en_b, we_b, rv_b;
    logic [7:0]   addr_b;
    logic [31:0]  data_b, rd_b;

    switch_box_param #(.WIDTH(1), .NUM_TRACKS(4), .OUT_SIDE_MASK(4'b0011), .CFG_ADDR_W(8)) dut_a (
        .clk(clk), .reset(rst_n), .in_wire(in_a), .pe_output(pe_a), .out_wire(out_a),
        .config_en(en_a), .config_we(we_a), .config_addr(addr_a), .config_data(data_a),
        .config_rd_data(rd_a), .config_rd_valid(rv_a));

    switch_box_param #(.WIDTH(8), .NUM_TRACKS(6), .OUT_SIDE_MASK(4'b1111), .CFG_ADDR_W(8)) dut_b (
        .clk(clk), .reset(rst_n), .in_wire(in_b), .pe_output(pe_b), .out_wire(out_b),
        .config_en(en_b), .config_we(we_b), .config_addr(addr_b), .config_data(data_b),
        .config_rd_data(rd_b), .config_rd_valid(rv_b));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        en;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [15:0] inw;
        logic        pe;
        logic [15:0] exp_out;
        logic        exp_rv;
        logic [31:0] exp_rd;
    } vec_a_t;

    vec_a_t va [12];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        en_a = 1'b0; we_a = 1'b0;
        en_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic wr_b(input logic [7:0] a, input logic [31:0] d);
        next_cycle();
        en_b = 1'b1; we_b = 1'b1; addr_b = a; data_b = d;
    endtask

    task automatic wr_b_all(input logic [31:0] d);
        for (int w = 0; w < 3; w++) wr_b(8'(w), d);
    endtask

    // Expected B outputs from the routing rule: side (s+k+1)%4, track (t+m+N-1)%N.
    function automatic logic [191:0] model_b(input logic [191:0] inw, input int k);
        logic [191:0] r;
        int m, st;
        r = '0;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < 6; t++) begin
                m  = (s + k + 1) % 4;
                st = (t + m + 5) % 6;
                r[(s*6+t)*8 +: 8] = inw[(m*6+st)*8 +: 8];
            end
        end
        return r;
    endfunction

    // Multi-cycle read: issue addresses back to back, check each one a cycle later.
    task automatic rd_b_seq(input logic [7:0] a [5], input logic [31:0] e [5], input string tag);
        for (int i = 0; i <= 5; i++) begin
            next_cycle();
            if (i < 5) begin
                en_b = 1'b1; we_b = 1'b0; addr_b = a[i];
            end
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("%s_rd%0d", tag, i-1), 192'(rd_b), 192'(e[i-1]));
                chk($sformatf("%s_rv%0d", tag, i-1), 192'(rv_b), 192'(1'b1));
            end
        end
        next_cycle();
        @(negedge clk);
        chk({tag, "_rv_idle"}, 192'(rv_b), 192'(1'b0));
        chk({tag, "_rd_hold"}, 192'(rd_b), 192'(e[4]));
    endtask

    initial begin
        logic [7:0]   ra [5];
        logic [31:0]  re [5];
        logic [191:0] p1, p2;

        rst_n = 1'b0;
        in_a = 16'hFFFF; pe_a = 1'b1; in_b = '1; pe_b = 8'hFF;
        en_a = 1'b1; we_a = 1'b1; addr_a = 8'h00; data_a = 32'hFFFF_FFFF;
        en_b = 1'b1; we_b = 1'b0; addr_b = 8'h00; data_b = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0;
        in_a = '0; pe_a = 1'b0; in_b = '0; pe_b = '0;
        @(negedge clk);
        chk("rst_out_a", 192'(out_a), 192'(16'h0000));
        chk("rst_out_b", out_b, '0);
        chk("rst_rd_b", 192'(rd_b), 192'(32'h0));
        chk("rst_rv_b", 192'(rv_b), 192'(1'b0));
        chk("rst_rv_a", 192'(rv_a), 192'(1'b0));

        // ---------------- Box A table ----------------
        //        en    we    addr   data           inw       pe    exp_out   rv    rd
        va[0]  = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 16'h0010, 1'b0, 16'h0001, 1'b0, 32'h0};
        va[1]  = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 16'h0100, 1'b0, 16'h0080, 1'b0, 32'h0};
        va[2]  = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 16'hFFFF, 1'b0, 16'h00FF, 1'b0, 32'h0};
        va[3]  = '{1'b1, 1'b1, 8'h00, 32'h0000_0003, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h0};
        va[4]  = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 32'h0};
        va[5]  = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h0};
        va[6]  = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 16'h0010, 1'b0, 16'h0000, 1'b0, 32'h0};
        va[7]  = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 32'h0};
        va[8]  = '{1'b1, 1'b1, 8'h01, 32'hFFFF_FFFF, 16'h0000, 1'b1, 16'h0001, 1'b0, 32'h0};
        va[9]  = '{1'b1, 1'b0, 8'h01, 32'h0000_0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 32'h0};
        va[10] = '{1'b1, 1'b0, 8'h00, 32'h0000_0000, 16'hFFFF, 1'b1, 16'h00FF, 1'b1, 32'h0};
        va[11] = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 32'h0000_0003};

        for (int i = 0; i < 12; i++) begin
            next_cycle();
            en_a = va[i].en; we_a = va[i].we; addr_a = va[i].addr; data_a = va[i].data;
            in_a = va[i].inw; pe_a = va[i].pe;
            @(negedge clk);
            chk($sformatf("a_vec%0d_out", i), 192'(out_a), 192'(va[i].exp_out));
            chk($sformatf("a_vec%0d_rv", i), 192'(rv_a), 192'(va[i].exp_rv));
            chk($sformatf("a_vec%0d_rd", i), 192'(rd_a), 192'(va[i].exp_rd));
        end

        // ---------------- Box A registered path and reset ----------------
        next_cycle();
        en_a = 1'b1; we_a = 1'b1; addr_a = 8'h00; data_a = 32'h0000_0007; pe_a = 1'b1; in_a = '0;
        @(negedge clk);
        chk("a_reg_wrcyc", 192'(out_a), 192'(16'h0001));
        next_cycle();
        pe_a = 1'b0;
        @(negedge clk);
        chk("a_reg_d1_hi", 192'(out_a), 192'(16'h0001));
        next_cycle();
        pe_a = 1'b1;
        @(negedge clk);
        chk("a_reg_d1_lo", 192'(out_a), 192'(16'h0000));
        next_cycle();
        pe_a = 1'b1; en_a = 1'b1; we_a = 1'b0; addr_a = 8'h00;
        @(negedge clk);
        chk("a_reg_d1_hi2", 192'(out_a), 192'(16'h0001));
        next_cycle();
        pe_a = 1'b1;
        @(negedge clk);
        chk("a_rd_word0_7", 192'(rd_a), 192'(32'h0000_0007));
        chk("a_rv_word0", 192'(rv_a), 192'(1'b1));
        // Reset together with a write: reset must win and drop the write.
        next_cycle();
        rst_n = 1'b0; en_a = 1'b1; we_a = 1'b1; addr_a = 8'h00; data_a = 32'h0000_0003;
        @(negedge clk);
        chk("a_pre_rst_reg", 192'(out_a), 192'(16'h0001));
        next_cycle();
        rst_n = 1'b1; pe_a = 1'b1; in_a = '0;
        @(negedge clk);
        chk("a_post_rst_out", 192'(out_a), 192'(16'h0000));
        chk("a_post_rst_rd", 192'(rd_a), 192'(32'h0));
        chk("a_post_rst_rv", 192'(rv_a), 192'(1'b0));
        next_cycle();
        in_a = 16'h0010;
        @(negedge clk);
        chk("a_post_rst_sel0", 192'(out_a), 192'(16'h0001));

        // ---------------- Box B config readback ----------------
        in_a = '0;
        wr_b_all(32'hA5A5_A5A5);
        ra = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd255};
        re = '{32'h2525_2525, 32'h2525_2525, 32'h2525_2525, 32'h0, 32'h0};
        rd_b_seq(ra, re, "b_a5");

        wr_b(8'd3, 32'hFFFF_FFFF);
        wr_b(8'd200, 32'h0000_0000);
        ra = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1};
        re = '{32'h2525_2525, 32'h2525_2525, 32'h2525_2525, 32'h0, 32'h2525_2525};
        rd_b_seq(ra, re, "b_oor_wr");

        // Write then read the same word in consecutive cycles.
        wr_b(8'd1, 32'h1234_5670);
        next_cycle();
        en_b = 1'b1; we_b = 1'b0; addr_b = 8'd1;
        next_cycle();
        @(negedge clk);
        chk("b_wr_then_rd", 192'(rd_b), 192'(32'h1234_5670 & 32'h7777_7777));

        // ---------------- Box B select sweep ----------------
        pe_b = 8'hC3;
        for (int k = 0; k < 3; k++) begin
            wr_b_all(32'h1111_1111 * 32'(k));
            next_cycle();
            for (int j = 0; j < 24; j++) begin
                in_b = '0;
                in_b[j*8 +: 8] = 8'h5A;
                @(negedge clk);
                chk($sformatf("b_sel%0d_in%0d", k, j), out_b, model_b(in_b, k));
                next_cycle();
            end
        end
        in_b = '1;
        wr_b_all(32'h3333_3333);
        next_cycle();
        @(negedge clk);
        chk("b_sel_pe", out_b, {24{8'hC3}});

        // ---------------- Box B reg_en 0->1 ----------------
        for (int i = 0; i < 24; i++) begin
            p1[i*8 +: 8] = 8'(i + 1);
            p2[i*8 +: 8] = 8'(8'h80 | i);
        end
        wr_b_all(32'h0000_0000);
        next_cycle();
        in_b = p1;
        @(negedge clk);
        chk("b_comb_p1", out_b, model_b(p1, 0));
        wr_b_all(32'h4444_4444);
        next_cycle();
        in_b = p2;
        @(negedge clk);
        chk("b_regen_p1", out_b, model_b(p1, 0));
        next_cycle();
        in_b = '0;
        @(negedge clk);
        chk("b_regen_p2", out_b, model_b(p2, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
